// File: rtl/pipe_pkg.sv
// Shared pipeline constants and encodings used by the hazard/forwarding logic.
package pipe_pkg;
    localparam int         NREG            = 32;
    localparam int         MAX_OUT_DEFAULT = 4;
    localparam logic [4:0] REG_ZERO        = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic lu;
        logic raw;
        logic waw;
        logic full;
    } hz_terms_t;
endpackage

// File: rtl/scb_busy_table.sv
// Busy bits for long-latency destinations, the in-flight counter and the sticky
// completion-protocol error flag.
module scb_busy_table #(
    parameter int NREG    = pipe_pkg::NREG,
    parameter int MAX_OUT = pipe_pkg::MAX_OUT_DEFAULT,
    parameter int OUTW    = 3,
    parameter int IW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [IW-1:0]   set_idx,
    input  logic            clr_en,
    input  logic [IW-1:0]   clr_idx,
    input  logic [IW-1:0]   rd_a_idx,
    input  logic [IW-1:0]   rd_b_idx,
    input  logic [IW-1:0]   rd_d_idx,
    output logic            rd_a,
    output logic            rd_b,
    output logic            rd_d,
    output logic [NREG-1:0] busy_vec,
    output logic [OUTW-1:0] out_cnt,
    output logic            full,
    output logic            err
);
    import pipe_pkg::*;

    logic [NREG-1:0] busy_q, busy_d;
    logic [OUTW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            clr_hit, clr_bad;

    assign full = (cnt_q == OUTW'(MAX_OUT));

    always_comb begin
        clr_hit = clr_en && (clr_idx != '0) && busy_q[clr_idx];
        clr_bad = clr_en && (clr_idx != '0) && !busy_q[clr_idx];
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        err_d   = err_q | clr_bad;
        // Completion is evaluated against the old bit; waw keeps set/clear on distinct regs.
        if (clr_hit) begin
            busy_d[clr_idx] = 1'b0;
            cnt_d           = cnt_d - OUTW'(1);
        end
        if (set_en && (set_idx != '0) && !full) begin
            busy_d[set_idx] = 1'b1;
            cnt_d           = cnt_d + OUTW'(1);
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign rd_a     = busy_q[rd_a_idx];
    assign rd_b     = busy_q[rd_b_idx];
    assign rd_d     = busy_q[rd_d_idx];
    assign busy_vec = busy_q;
    assign out_cnt  = cnt_q;
    assign err      = err_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/flush generation for hazards forwarding cannot cover: load-use, long-op
// RAW/WAW, outstanding limit, and branch redirect.
module hazard_scoreboard #(
    parameter int NREG    = pipe_pkg::NREG,
    parameter int MAX_OUT = pipe_pkg::MAX_OUT_DEFAULT,
    parameter int OUTW    = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      RS1_D,
    input  logic [4:0]      RS2_D,
    input  logic            UseRS1_D,
    input  logic            UseRS2_D,
    input  logic [4:0]      RD_D,
    input  logic            RegWriteD,
    input  logic            LongD,
    input  logic [4:0]      RD_E,
    input  logic            RegWriteE,
    input  logic            ResultSrcE0,
    input  logic            PCSrcE,
    input  logic            CmpValid,
    input  logic [4:0]      CmpRD,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD,
    output logic            FlushE,
    output logic [NREG-1:0] BusyVec,
    output logic [OUTW-1:0] OutCnt,
    output logic            ScbErr
);
    import pipe_pkg::*;

    hz_terms_t hz;
    logic      busy_rs1, busy_rs2, busy_rd, full, any_hz, acc, rd_nz;

    scb_busy_table #(.NREG(NREG), .MAX_OUT(MAX_OUT), .OUTW(OUTW)) u_tbl (
        .clk      (clk),
        .rst      (rst),
        .set_en   (acc),
        .set_idx  (RD_D),
        .clr_en   (CmpValid),
        .clr_idx  (CmpRD),
        .rd_a_idx (RS1_D),
        .rd_b_idx (RS2_D),
        .rd_d_idx (RD_D),
        .rd_a     (busy_rs1),
        .rd_b     (busy_rs2),
        .rd_d     (busy_rd),
        .busy_vec (BusyVec),
        .out_cnt  (OutCnt),
        .full     (full),
        .err      (ScbErr)
    );

    always_comb begin
        rd_nz   = (RD_D != REG_ZERO);
        hz.lu   = ResultSrcE0 && RegWriteE && (RD_E != REG_ZERO) &&
                  ((UseRS1_D && (RD_E == RS1_D)) || (UseRS2_D && (RD_E == RS2_D)));
        hz.raw  = (UseRS1_D && busy_rs1) || (UseRS2_D && busy_rs2);
        hz.waw  = RegWriteD && rd_nz && busy_rd;
        hz.full = RegWriteD && LongD && rd_nz && full;
        any_hz  = |hz;
        acc     = rst && RegWriteD && LongD && rd_nz && !any_hz && !PCSrcE;

        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        // Redirect squashes Decode anyway, so stalling it would only lose the new fetch.
        if (rst) begin
            if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else begin
                StallF = any_hz;
                StallD = any_hz;
                FlushE = any_hz;
            end
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: expected outputs from a reference model are queued as each
// cycle's stimulus is applied and popped when the outputs are sampled.
module tb_hazard_scoreboard;
    import pipe_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [4:0]  RS1_D, RS2_D, RD_D, RD_E, CmpRD;
    logic        UseRS1_D, UseRS2_D, RegWriteD, LongD, RegWriteE, ResultSrcE0, PCSrcE, CmpValid;
    logic        StallF, StallD, FlushD, FlushE, ScbErr;
    logic [31:0] BusyVec;
    logic [2:0]  OutCnt;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst_n),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .UseRS1_D(UseRS1_D), .UseRS2_D(UseRS2_D),
        .RD_D(RD_D), .RegWriteD(RegWriteD), .LongD(LongD),
        .RD_E(RD_E), .RegWriteE(RegWriteE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .CmpValid(CmpValid), .CmpRD(CmpRD),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .BusyVec(BusyVec), .OutCnt(OutCnt), .ScbErr(ScbErr)
    );

    typedef struct {
        logic [4:0] rs1, rs2, rd, rde, crd;
        logic       u1, u2, rw, lg, rwe, ld, pcs, cv;
    } stim_t;

    typedef struct {
        logic        sf, sd, fd, fe, err;
        logic [31:0] busy;
        logic [2:0]  cnt;
    } exp_t;

    exp_t  expq[$];
    bit    mbusy[32];
    int    mcnt;
    bit    merr;
    int    checks = 0, errors = 0;
    stim_t s;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic stim_t nop();
        stim_t r;
        r = '{default: '0};
        return r;
    endfunction

    function automatic stim_t issue(input logic [4:0] r);
        stim_t t;
        t = nop(); t.rw = 1'b1; t.lg = 1'b1; t.rd = r;
        return t;
    endfunction

    function automatic stim_t use1(input logic [4:0] r);
        stim_t t;
        t = nop(); t.u1 = 1'b1; t.rs1 = r;
        return t;
    endfunction

    task automatic apply(input stim_t t);
        RS1_D = t.rs1; RS2_D = t.rs2; UseRS1_D = t.u1; UseRS2_D = t.u2;
        RD_D = t.rd; RegWriteD = t.rw; LongD = t.lg;
        RD_E = t.rde; RegWriteE = t.rwe; ResultSrcE0 = t.ld; PCSrcE = t.pcs;
        CmpValid = t.cv; CmpRD = t.crd;
    endtask

    // One pipeline cycle: want_stall is the hand-derived StallD for this cycle.
    task automatic drive(input stim_t t, input int want_stall);
        bit   lu, raw, waw, full, hz, acc;
        exp_t e, g;
        apply(t);
        lu   = t.ld && t.rwe && t.rde != 0 && ((t.u1 && t.rde == t.rs1) || (t.u2 && t.rde == t.rs2));
        raw  = (t.u1 && mbusy[t.rs1]) || (t.u2 && mbusy[t.rs2]);
        waw  = t.rw && t.rd != 0 && mbusy[t.rd];
        full = t.rw && t.lg && t.rd != 0 && mcnt == 4;
        hz   = lu || raw || waw || full;
        e.sf = t.pcs ? 1'b0 : hz;
        e.sd = e.sf;
        e.fd = t.pcs;
        e.fe = t.pcs ? 1'b1 : hz;
        for (int i = 0; i < 32; i++) e.busy[i] = mbusy[i];
        e.cnt = 3'(mcnt);
        e.err = merr;
        expq.push_back(e);

        @(negedge clk);
        if (expq.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            g = expq.pop_front();
            chk("StallF", StallF, g.sf);
            chk("StallD", StallD, g.sd);
            chk("FlushD", FlushD, g.fd);
            chk("FlushE", FlushE, g.fe);
            chk("BusyVec", BusyVec, g.busy);
            chk("OutCnt", OutCnt, g.cnt);
            chk("ScbErr", ScbErr, g.err);
        end
        chk("stall_hand", StallD, want_stall);

        acc = t.rw && t.lg && t.rd != 0 && !hz && !t.pcs;
        if (t.cv && t.crd != 0) begin
            if (mbusy[t.crd]) begin
                mbusy[t.crd] = 1'b0;
                mcnt--;
            end else begin
                merr = 1'b1;
            end
        end
        if (acc) begin
            mbusy[t.rd] = 1'b1;
            mcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        mcnt = 0;
        merr = 1'b0;
        // Hazard-provoking inputs while held in reset: outputs must stay quiet.
        s = use1(5); s.ld = 1'b1; s.rwe = 1'b1; s.rde = 5'd5; s.pcs = 1'b1;
        apply(s);
        #12;
        chk("rst_stallf", StallF, 0);
        chk("rst_flushd", FlushD, 0);
        chk("rst_flushe", FlushE, 0);
        chk("rst_busy", BusyVec, 0);
        chk("rst_cnt", OutCnt, 0);
        chk("rst_err", ScbErr, 0);
        apply(nop());
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Load-use: exactly one bubble, no tracking.
        s = use1(5); s.ld = 1'b1; s.rwe = 1'b1; s.rde = 5'd5;
        drive(s, 1);
        drive(use1(5), 0);
        chk("lu_nobusy", BusyVec, 0);

        // Long RAW on x7, completing while the consumer waits.
        drive(issue(7), 0);
        chk("div_busy7", BusyVec[7], 1);
        chk("div_cnt", OutCnt, 1);
        drive(use1(7), 1);
        drive(use1(7), 1);
        s = use1(7); s.cv = 1'b1; s.crd = 5'd7;
        drive(s, 1);
        chk("raw_clr7", BusyVec[7], 0);
        drive(use1(7), 0);

        // WAW on x9.
        drive(issue(9), 0);
        s = nop(); s.rw = 1'b1; s.rd = 5'd9;
        drive(s, 1);
        drive(s, 1);
        s.cv = 1'b1; s.crd = 5'd9;
        drive(s, 1);
        s.cv = 1'b0;
        drive(s, 0);

        // Outstanding limit.
        for (int r = 1; r <= 4; r++) drive(issue(5'(r)), 0);
        chk("full_cnt", OutCnt, 4);
        drive(issue(6), 1);
        drive(issue(6), 1);
        s = issue(6); s.cv = 1'b1; s.crd = 5'd2;
        drive(s, 1);
        drive(issue(6), 0);
        chk("full_cnt_back", OutCnt, 4);
        chk("full_busy6", BusyVec[6], 1);
        s = nop(); s.cv = 1'b1; s.crd = 5'd3;
        drive(s, 0);
        s = issue(10); s.cv = 1'b1; s.crd = 5'd4;
        drive(s, 0);
        chk("simul_cnt", OutCnt, 3);
        chk("simul_busy", BusyVec, 32'h0000_0442);

        // Redirect beats load-use; long op in Decode is dropped.
        s = issue(11); s.u1 = 1'b1; s.rs1 = 5'd5; s.ld = 1'b1; s.rwe = 1'b1; s.rde = 5'd5; s.pcs = 1'b1;
        drive(s, 0);
        chk("redir_busy11", BusyVec[11], 0);
        chk("redir_cnt", OutCnt, 3);

        // Completion protocol errors.
        s = nop(); s.cv = 1'b1; s.crd = 5'd0;
        drive(s, 0);
        chk("cmp_x0_noerr", ScbErr, 0);
        s.crd = 5'd12;
        drive(s, 0);
        chk("cmp_err", ScbErr, 1);
        drive(nop(), 0);
        drive(nop(), 0);
        chk("cmp_err_sticky", ScbErr, 1);

        // Reset mid-run with three ops in flight.
        apply(use1(1));
        #1;
        chk("pre_rst_stall", StallF, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stallf", StallF, 0);
        chk("mid_rst_stalld", StallD, 0);
        chk("mid_rst_flushe", FlushE, 0);
        chk("mid_rst_busy", BusyVec, 0);
        chk("mid_rst_cnt", OutCnt, 0);
        chk("mid_rst_err", ScbErr, 0);
        @(negedge clk);
        chk("mid_rst_hold", {28'd0, StallF, StallD, FlushD, FlushE}, 0);
        for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
        mcnt = 0;
        merr = 1'b0;
        apply(nop());
        @(posedge clk); #1;
        rst_n = 1'b1;

        drive(issue(7), 0);
        chk("post_rst_cnt", OutCnt, 1);
        drive(use1(7), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side hazard control for the 5-stage RV32I pipeline: records destination registers of long-latency ops (divider, multi-cycle memory) when they leave Decode, and clears them when the unit reports completion.
- Generates Fetch/Decode stalls and Decode/Execute flushes for load-use, scoreboard RAW, WAW, outstanding-limit and branch-redirect cases.
- Sits beside the existing combinational forwarding logic. It covers the hazards that forwarding cannot resolve.

Parameters:
- NREG, 32, number of architectural registers; x0 is never tracked.
- MAX_OUT, 4, maximum long-latency ops in flight at once.
- OUTW, 3, width of the outstanding counter; must hold MAX_OUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- RS1_D  in  5  Decode source 1.
- RS2_D  in  5  Decode source 2.
- UseRS1_D  in  1  Decode instruction reads RS1_D.
- UseRS2_D  in  1  Decode instruction reads RS2_D.
- RD_D  in  5  Decode destination.
- RegWriteD  in  1  Decode instruction writes RD_D.
- LongD  in  1  Decode instruction is long-latency; meaningful only with RegWriteD.
- RD_E  in  5  Execute destination.
- RegWriteE  in  1  Execute writes RD_E.
- ResultSrcE0  in  1  Execute instruction is a load.
- PCSrcE  in  1  branch/jump taken in Execute.
- CmpValid  in  1  long-latency unit writes back this cycle.
- CmpRD  in  5  register completed.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID.
- FlushD  out  1  clear IF/ID.
- FlushE  out  1  clear ID/EX, inserting a bubble.
- BusyVec  out  NREG  scoreboard state, for debug/verification.
- OutCnt  out  OUTW  long ops in flight.
- ScbErr  out  1  sticky protocol error.

Behaviour:
- Reset (rst=0, async):
  - busy bits, OutCnt and ScbErr cleared.
  - StallF, StallD, FlushD and FlushE forced to 0 combinationally while rst=0.
  - Reset mid-operation discards all in-flight tracking.
- Hazard terms (combinational, registered state only; no same-cycle completion bypass):
  - lu = ResultSrcE0 & RegWriteE & RD_E!=0 & ((UseRS1_D & RD_E==RS1_D) | (UseRS2_D & RD_E==RS2_D)).
  - raw = (UseRS1_D & busy[RS1_D]) | (UseRS2_D & busy[RS2_D]); x0 is never busy.
  - waw = RegWriteD & RD_D!=0 & busy[RD_D].
  - full = RegWriteD & LongD & RD_D!=0 & OutCnt==MAX_OUT.
  - hz = lu | raw | waw | full.
- Outputs:
  - PCSrcE=1 (redirect wins): StallF=StallD=0, FlushD=FlushE=1.
  - Otherwise: StallF=StallD=hz, FlushD=0, FlushE=hz.
- Issue accept: acc = rst & RegWriteD & LongD & RD_D!=0 & ~hz & ~PCSrcE.
  - On a clk edge with acc: busy[RD_D] set, OutCnt incremented.
- Completion on a clk edge with CmpValid & CmpRD!=0:
  - If busy[CmpRD]=1: bit cleared, OutCnt decremented.
  - If busy[CmpRD]=0: ignored, ScbErr set. ScbErr stays set until reset.
  - CmpValid with CmpRD=0: ignored, no error.
- Simultaneous issue and completion:
  - Different registers: both applied, OutCnt net unchanged.
  - Same register cannot occur, since waw blocks issue to a busy register.
- Stall release timing:
  - A consumer of rd stalls through the completion cycle and proceeds on the following cycle, when busy[rd]=0.
  - Completion of any op frees a full slot on the following cycle.
- Load-use costs exactly one bubble. On the next cycle the load is in Memory and the forwarding path covers it.
- OutCnt never exceeds MAX_OUT and never underflows.

Decomposition:
- Shared package pipe_pkg holds:
  - REG_ZERO (5'd0).
  - NREG.
  - MAX_OUT_DEFAULT.
  - The forward-select encodings, so the hazard logic agrees on one set.
- One natural sub-module, scb_busy_table, owns:
  - Busy bits, set/clear ports, two read ports plus a destination read port.
  - The OutCnt counter and ScbErr.
- The top level holds only the combinational stall/flush priority logic.

Test Plan:
- Load-use: load x5 in Execute (ResultSrcE0=1, RD_E=5); Decode add reads x5 -> one cycle of StallF=StallD=FlushE=1, then all 0; no busy bit set.
- Long RAW: issue div x7 (LongD=1); following add reads x7 -> stalled each cycle; CmpValid/CmpRD=7 at cycle N -> stall still 1 at N, 0 at N+1, BusyVec[7] 0 after edge N.
- WAW: x9 busy; Decode add writes x9 (no source use) -> stalled until the cycle after completion of x9.
- Full: issue long ops to x1..x4 -> OutCnt=4; fifth long op to x6 stalls; complete x2 -> fifth issues the next cycle, OutCnt back to 4.
- Redirect priority: lu true and PCSrcE=1 in the same cycle -> StallF=StallD=0, FlushD=FlushE=1; a long op in Decode is not recorded, OutCnt unchanged.
- Errors/reset:
  - CmpValid with CmpRD=12 and x12 not busy -> ScbErr=1 and stays 1.
  - rst pulsed low mid-run with 3 ops in flight -> BusyVec=0, OutCnt=0, ScbErr=0, all stall/flush outputs 0 while low.
